// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the system-RAM port arbiter.
//               Provides the arbiter state encoding, default bus widths and
//               the width of the burst-length counter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_DEFAULT_ADDR_W = 16;
    localparam int c_DEFAULT_DATA_W = 16;

    // Wide enough for any burst length up to 255.
    localparam int c_BURST_CNT_W    = 8;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Starting at the index after
//               i_last and wrapping, selects the first asserted request.
// Ports       : i_req    - request vector, one bit per requester
//               i_last   - index of the most recently granted requester
//               o_onehot - one-hot winner (all zero when no request)
//               o_idx    - encoded winner index (0 when no request)
//               o_found  - at least one request is asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    // Two ordered passes: first the indices above i_last, then the indices
    // from 0 up to and including i_last. The first hit in that order is the
    // closest requester after i_last with wrap-around.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_found  = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_found && i_req[j] && (IDX_W'(j) > i_last)) begin
                o_found     = 1'b1;
                o_onehot[j] = 1'b1;
                o_idx       = IDX_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_found && i_req[j] && (IDX_W'(j) <= i_last)) begin
                o_found     = 1'b1;
                o_onehot[j] = 1'b1;
                o_idx       = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one port of the 64Kx16 system RAM between NUM_REQ bus
//               masters. Round-robin arbitration resolved in the same cycle,
//               with optional bounded burst locking. The RAM samples address,
//               write data and write enable on the falling edge and returns
//               read data on the following cycle.
// Ports       : clock, reset       - clock, async active-high reset
//               req/lock/we        - per-requester request, burst lock, write
//               addr/wdata         - packed per-requester address / data
//               gnt                - one-hot grant, valid in the issue cycle
//               rvalid/rdata       - one-hot read return, shared read data
//               mem_address        - RAM port address
//               mem_write_data     - RAM port write data
//               mem_write_enable   - RAM port write enable
//               mem_read_data      - RAM port read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = c_DEFAULT_ADDR_W,
    parameter int DATA_W    = c_DEFAULT_DATA_W,
    parameter int MAX_BURST = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_write_data,
    output logic                      mem_write_enable,
    input  logic [DATA_W-1:0]         mem_read_data
);

    localparam int                       c_IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_IDX_W-1:0]       c_LAST_RST  = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_BURST_CNT_W-1:0] c_MAX_BURST = c_BURST_CNT_W'(MAX_BURST);
    localparam logic [c_BURST_CNT_W-1:0] c_CNT_ONE   = c_BURST_CNT_W'(1);
    localparam bit                       c_BURST_EN  = (MAX_BURST > 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    arb_state_t                r_state;
    arb_state_t                w_state_nxt;
    logic [c_IDX_W-1:0]        r_last;
    logic [c_IDX_W-1:0]        w_last_nxt;
    logic [c_BURST_CNT_W-1:0]  r_count;
    logic [c_BURST_CNT_W-1:0]  w_count_nxt;
    logic [c_BURST_CNT_W-1:0]  w_count_inc;
    logic [NUM_REQ-1:0]        r_rd_pend;

    // ------------------------------------------------------------------------
    // Per-requester views of the packed address / data buses
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] w_wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_rr_onehot;
    logic [c_IDX_W-1:0] w_rr_idx;
    logic               w_rr_found;
    logic [NUM_REQ-1:0] w_owner_onehot;
    logic               w_owner_hold;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [c_IDX_W-1:0] w_win_idx;
    logic               w_win_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_onehot (w_rr_onehot),
        .o_idx    (w_rr_idx),
        .o_found  (w_rr_found)
    );

    always_comb begin
        w_owner_onehot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_owner_onehot[j] = (c_IDX_W'(j) == r_last);
        end
    end

    // In BURST the owner keeps the port for as long as it keeps requesting;
    // once it lets go, round-robin picks this cycle's winner instead.
    assign w_owner_hold = (r_state == BURST) && req[r_last];
    assign w_win_idx    = w_owner_hold ? r_last : w_rr_idx;
    assign w_win_onehot = w_owner_hold ? w_owner_onehot : w_rr_onehot;

    // Reset blanks the grant immediately, even though the requests feeding
    // the picker are still asserted.
    assign w_win_valid  = (w_owner_hold || w_rr_found) && !reset;

    // ------------------------------------------------------------------------
    // RAM port and requester outputs
    // ------------------------------------------------------------------------
    // With no winner the index falls back to 0, so requester 0's address and
    // data sit on the RAM port as harmless, defined values.
    assign gnt              = w_win_valid ? w_win_onehot : '0;
    assign mem_address      = w_addr_arr[w_win_idx];
    assign mem_write_data   = w_wdata_arr[w_win_idx];
    assign mem_write_enable = w_win_valid && we[w_win_idx];

    assign rvalid = r_rd_pend;
    assign rdata  = mem_read_data;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    assign w_count_inc = r_count + c_CNT_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_count_nxt = r_count;

        if (w_win_valid) begin
            w_last_nxt = w_win_idx;
        end

        case (r_state)
            ARB: begin
                // The count includes the grant that opens the burst.
                if (c_BURST_EN && w_win_valid && lock[w_win_idx]) begin
                    w_state_nxt = BURST;
                    w_count_nxt = c_CNT_ONE;
                end
            end
            BURST: begin
                if (w_owner_hold && lock[r_last] && (w_count_inc < c_MAX_BURST)) begin
                    w_count_nxt = w_count_inc;
                end else begin
                    // Owner released the port, dropped lock, or this grant
                    // reached the burst limit.
                    w_state_nxt = ARB;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ARB;
                w_count_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ARB;
            r_last    <= c_LAST_RST;
            r_count   <= '0;
            r_rd_pend <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_count   <= w_count_nxt;
            r_rd_pend <= gnt & ~we;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard testbench for mem_port_arbiter (3 requesters,
//               MAX_BURST = 4) with a falling-edge 64Kx16 RAM model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req   = 3'b000;
    logic [2:0]  lock  = 3'b000;
    logic [2:0]  we    = 3'b000;
    logic [47:0] addr  = {16'h0300, 16'h0200, 16'h0100};
    logic [47:0] wdata = '0;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [15:0] rdata;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic        mem_write_enable;
    logic [15:0] mem_read_data = '0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [2:0] gnt;
        logic       mwe;
    } gexp_t;

    typedef struct {
        int          cyc;
        logic [2:0]  who;
        logic [15:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t m_g;
    rexp_t m_r;

    logic [15:0] mem [0:65535];

    mem_port_arbiter #(
        .NUM_REQ   (3),
        .ADDR_W    (16),
        .DATA_W    (16),
        .MAX_BURST (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req              (req),
        .lock             (lock),
        .we               (we),
        .addr             (addr),
        .wdata            (wdata),
        .gnt              (gnt),
        .rvalid           (rvalid),
        .rdata            (rdata),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM: contents preset to addr ^ 0xA5A5, registered on the falling edge.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    end

    always @(negedge clock) begin
        if (mem_write_enable) mem[mem_address] <= mem_write_data;
        mem_read_data <= mem[mem_address];
    end

    // Monitor: grant checks pop one entry per stimulus cycle, read-return
    // checks pop whenever rvalid is presented.
    always @(negedge clock) begin
        if (gq.size() > 0) begin
            m_g = gq.pop_front();
            n_vec++;
            if (gnt !== m_g.gnt || mem_write_enable !== m_g.mwe) begin
                n_err++;
                $display("FAIL grant cyc %0d: gnt=%b mwe=%b, expected gnt=%b mwe=%b",
                         cyc, gnt, mem_write_enable, m_g.gnt, m_g.mwe);
            end
        end
        if (rvalid != 3'b000) begin
            n_vec++;
            if (rq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected rvalid cyc %0d: rvalid=%b rdata=%h, expected none",
                         cyc, rvalid, rdata);
            end else begin
                m_r = rq.pop_front();
                if (m_r.cyc != cyc || rvalid !== m_r.who || rdata !== m_r.data) begin
                    n_err++;
                    $display("FAIL read return cyc %0d: rvalid=%b rdata=%h, expected cyc %0d rvalid=%b rdata=%h",
                             cyc, rvalid, rdata, m_r.cyc, m_r.who, m_r.data);
                end
            end
        end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missing rvalid cyc %0d: rvalid=%b, expected rvalid=%b rdata=%h",
                     cyc, rvalid, rq[0].who, rq[0].data);
            void'(rq.pop_front());
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One stimulus cycle: requester 0 uses 0x0100, requester 2 uses 0x0300,
    // requester 1 uses a1. eg/ed are the hand-computed grant and read data.
    task automatic step(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                        input logic [15:0] a1, input logic [15:0] wd,
                        input logic [2:0] eg, input logic [15:0] ed);
        gexp_t g;
        rexp_t e;
        @(posedge clock);
        #1;
        req   = r;
        lock  = l;
        we    = w;
        addr  = {16'h0300, a1, 16'h0100};
        wdata = {wd, wd, wd};
        g.gnt = eg;
        g.mwe = |(eg & w);
        gq.push_back(g);
        if ((eg & ~w) != 3'b000) begin
            e.cyc  = cyc + 1;
            e.who  = eg;
            e.data = ed;
            rq.push_back(e);
        end
    endtask

    task automatic idle();
        step(3'b000, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b000, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state: outputs blanked even with every requester asking.
        #1 reset = 1'b1;
        #1 req = 3'b111;
        we = 3'b111;
        #1;
        chk("reset gnt", 16'(gnt), 16'h0000);
        chk("reset mwe", 16'(mem_write_enable), 16'h0000);
        chk("reset rvalid", 16'(rvalid), 16'h0000);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        req   = 3'b000;
        we    = 3'b000;

        // Round-robin over all three, reads only.
        step(3'b111, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b001, 16'hA4A5);
        step(3'b111, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b010, 16'hA7A5);
        step(3'b111, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b100, 16'hA6A5);
        step(3'b111, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b001, 16'hA4A5);
        step(3'b111, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b010, 16'hA7A5);
        step(3'b111, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b100, 16'hA6A5);

        // Reset asserted mid-cycle while a write is being granted and a read
        // return is on the bus.
        @(posedge clock);
        #1;
        req = 3'b111;
        we  = 3'b001;
        #1;
        chk("pre-reset rvalid", 16'(rvalid), 16'h0004);
        chk("pre-reset gnt", 16'(gnt), 16'h0001);
        chk("pre-reset mwe", 16'(mem_write_enable), 16'h0001);
        rq.delete();
        reset = 1'b1;
        #1;
        chk("mid-cycle reset gnt", 16'(gnt), 16'h0000);
        chk("mid-cycle reset rvalid", 16'(rvalid), 16'h0000);
        chk("mid-cycle reset mwe", 16'(mem_write_enable), 16'h0000);
        @(posedge clock);
        #1;
        reset = 1'b0;
        req   = 3'b000;
        we    = 3'b000;

        // Write then read back through requester 1.
        step(3'b010, 3'b000, 3'b010, 16'h1234, 16'hBEEF, 3'b010, 16'h0000);
        step(3'b010, 3'b000, 3'b000, 16'h1234, 16'h0000, 3'b010, 16'hBEEF);
        idle();

        // Burst bound: requester 2 locked, others requesting constantly.
        repeat (4) step(3'b111, 3'b100, 3'b000, 16'h0200, 16'h0000, 3'b100, 16'hA6A5);
        step(3'b111, 3'b100, 3'b000, 16'h0200, 16'h0000, 3'b001, 16'hA4A5);
        step(3'b111, 3'b100, 3'b000, 16'h0200, 16'h0000, 3'b010, 16'hA7A5);
        step(3'b111, 3'b100, 3'b000, 16'h0200, 16'h0000, 3'b100, 16'hA6A5);
        step(3'b011, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b001, 16'hA4A5);

        // Burst early end: requester 0 drops lock on its 2nd grant.
        step(3'b010, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b010, 16'hA7A5);
        step(3'b011, 3'b001, 3'b000, 16'h0200, 16'h0000, 3'b001, 16'hA4A5);
        step(3'b011, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b001, 16'hA4A5);
        step(3'b011, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b010, 16'hA7A5);
        step(3'b011, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b001, 16'hA4A5);

        // Reset during requester 0's 3rd locked read.
        step(3'b010, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b010, 16'hA7A5);
        step(3'b001, 3'b001, 3'b000, 16'h0200, 16'h0000, 3'b001, 16'hA4A5);
        step(3'b001, 3'b001, 3'b000, 16'h0200, 16'h0000, 3'b001, 16'hA4A5);
        @(posedge clock);
        #1;
        req  = 3'b001;
        lock = 3'b001;
        we   = 3'b000;
        #1;
        chk("burst 3rd gnt", 16'(gnt), 16'h0001);
        chk("burst 2nd rvalid", 16'(rvalid), 16'h0001);
        rq.delete();
        reset = 1'b1;
        req   = 3'b000;
        lock  = 3'b000;
        #1;
        chk("burst reset gnt", 16'(gnt), 16'h0000);
        chk("burst reset rvalid", 16'(rvalid), 16'h0000);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(3'b101, 3'b000, 3'b000, 16'h0200, 16'h0000, 3'b001, 16'hA4A5);
        idle();
        idle();

        @(posedge clock);
        #1;
        chk("scoreboard drained", 16'(rq.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
